// File: rtl/wave_capture.sv
// Records a 256-sample waveform window, triggered on a positive-going zero
// crossing, into the half of a double-buffered RAM that the display is not reading.
module wave_capture #(
  parameter int SAMPLE_COUNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        new_sample_ready,
  input  logic [15:0]                 new_sample_in,
  input  logic                        wave_display_idle,
  output logic [SAMPLE_COUNT_WIDTH:0] write_address,
  output logic                        write_enable,
  output logic [7:0]                  write_sample,
  output logic                        read_index
);

  localparam int CW = SAMPLE_COUNT_WIDTH;

  typedef enum logic [1:0] {
    S_ARMED,
    S_ACTIVE,
    S_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   prev_q, prev_d;
  logic          rd_idx_q, rd_idx_d;
  logic          we_q, we_d;
  logic [CW:0]   addr_q, addr_d;
  logic [7:0]    wsmp_q, wsmp_d;

  logic          crossing;
  logic [7:0]    conv;

  assign crossing = new_sample_ready & prev_q[15] & ~new_sample_in[15];
  assign conv     = {~new_sample_in[15], new_sample_in[14:8]};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    prev_d   = prev_q;
    rd_idx_d = rd_idx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wsmp_d   = wsmp_q;

    if (new_sample_ready) begin
      prev_d = new_sample_in;
    end

    unique case (state_q)
      S_ARMED: begin
        if (crossing) begin
          we_d    = 1'b1;
          addr_d  = {~rd_idx_q, {CW{1'b0}}};
          wsmp_d  = conv;
          count_d = CW'(1);
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (new_sample_ready) begin
          we_d    = 1'b1;
          addr_d  = {~rd_idx_q, count_q};
          wsmp_d  = conv;
          count_d = count_q + CW'(1);
          if (&count_q) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Swap only while the display is off the RAM, to avoid tearing.
        if (wave_display_idle) begin
          rd_idx_d = ~rd_idx_q;
          state_d  = S_ARMED;
        end
      end
      default: begin
        state_d = S_ARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_ARMED;
      count_q  <= '0;
      prev_q   <= '0;
      rd_idx_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wsmp_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      prev_q   <= prev_d;
      rd_idx_q <= rd_idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wsmp_q   <= wsmp_d;
    end
  end

  assign write_address = addr_q;
  assign write_enable  = we_q;
  assign write_sample  = wsmp_q;
  assign read_index    = rd_idx_q;

endmodule

// File: tb/tb_wave_capture.sv
// Randomized and directed bench for wave_capture against a
// sample-stream reference model.
module tb_wave_capture;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int n_checks;
  int n_fail;

  // Model: m_cnt = samples written in current window; 256 means waiting.
  int         m_cnt;
  int         m_prev;
  logic       m_we;
  logic       m_ri;
  logic [8:0] m_addr;
  logic [7:0] m_ws;

  wave_capture #(.SAMPLE_COUNT_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic rst, input logic rdy,
                     input logic [15:0] s, input logic idle);
    int sv;
    reset             = rst;
    new_sample_ready  = rdy;
    new_sample_in     = s;
    wave_display_idle = idle;
    @(posedge clk);
    #1;
    sv   = int'($signed(s));
    m_we = 1'b0;
    if (rst) begin
      m_cnt  = 0;
      m_prev = 0;
      m_ri   = 1'b0;
      m_addr = '0;
      m_ws   = '0;
    end else begin
      if (m_cnt == 256) begin
        if (idle) begin
          m_ri  = ~m_ri;
          m_cnt = 0;
        end
      end else if (rdy && (m_cnt > 0 || (m_prev < 0 && sv >= 0))) begin
        m_we   = 1'b1;
        m_addr = 9'((m_ri ? 0 : 256) + m_cnt);
        m_ws   = 8'((sv + 32768) / 256);
        m_cnt  = m_cnt + 1;
      end
      if (rdy) m_prev = sv;
    end
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b1, 16'h1234, 1'b1);
    n_checks++;
    if (write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_we got %b want 0", write_enable);
    end
    n_checks++;
    if (write_address !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_addr got %h want 000", write_address);
    end
    n_checks++;
    if (write_sample !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ws got %h want 00", write_sample);
    end
    n_checks++;
    if (read_index !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ri got %b want 0", read_index);
    end
  endtask

  task automatic test_trigger();
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'hFF9C, 1'b0);
    n_checks++;
    if (write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL trig_neg_we got %b want 0", write_enable);
    end
    cyc(1'b0, 1'b1, 16'd50, 1'b0);
    n_checks++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 ||
        write_sample !== 8'h80) begin
      n_fail++;
      $display("FAIL trig_write got we=%b a=%h s=%h want 1 100 80",
               write_enable, write_address, write_sample);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (write_enable !== 1'b0 || write_address !== 9'h100) begin
      n_fail++;
      $display("FAIL trig_pulse got we=%b a=%h want 0 100",
               write_enable, write_address);
    end
    cyc(1'b0, 1'b1, 16'h8000, 1'b0);
    n_checks++;
    if (write_enable !== 1'b1 || write_address !== 9'h101) begin
      n_fail++;
      $display("FAIL trig_active got we=%b a=%h want 1 101",
               write_enable, write_address);
    end
  endtask

  task automatic test_negative_going();
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h7FFF, 1'b0);
    cyc(1'b0, 1'b1, 16'h8000, 1'b0);
    n_checks++;
    if (write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_going_we got %b want 0", write_enable);
    end
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    n_checks++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 ||
        write_sample !== 8'h80) begin
      n_fail++;
      $display("FAIL zero_cross got we=%b a=%h s=%h want 1 100 80",
               write_enable, write_address, write_sample);
    end
  endtask

  // Continues the window opened by test_negative_going.
  task automatic test_full_window();
    int writes;
    logic [15:0] s;
    writes = 1;
    for (int i = 1; i < 256; i++) begin
      s = 16'($urandom);
      cyc(1'b0, 1'b1, s, 1'b0);
      if (write_enable === 1'b1) writes++;
      n_checks++;
      if (write_enable !== 1'b1 || write_address !== 9'(256 + i) ||
          write_sample !== m_ws) begin
        n_fail++;
        $display("FAIL window_write[%0d] got we=%b a=%h s=%h want 1 %h %h",
                 i, write_enable, write_address, write_sample,
                 9'(256 + i), m_ws);
      end
    end
    n_checks++;
    if (writes != 256 || write_address !== 9'h1FF) begin
      n_fail++;
      $display("FAIL window_total got %0d last=%h want 256 1ff",
               writes, write_address);
    end
    cyc(1'b0, 1'b1, 16'h0123, 1'b0);
    n_checks++;
    if (write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL window_257 got we=%b want 0", write_enable);
    end
  endtask

  task automatic test_wait_swap();
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b0, 1'($urandom), 16'($urandom), 1'b0);
      if (read_index !== 1'b0 || write_enable !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wait_hold got %0d bad cycles want 0", bad);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++;
    if (read_index !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_ri got %b want 1", read_index);
    end
    cyc(1'b0, 1'b1, 16'hFF00, 1'b0);
    cyc(1'b0, 1'b1, 16'h0100, 1'b0);
    n_checks++;
    if (write_enable !== 1'b1 || write_address !== 9'h000 ||
        write_sample !== 8'h81) begin
      n_fail++;
      $display("FAIL swap_trig got we=%b a=%h s=%h want 1 000 81",
               write_enable, write_address, write_sample);
    end
  endtask

  task automatic test_reset_mid();
    int writes;
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    writes = 0;
    for (int i = 0; i < 400 && writes < 100; i++) begin
      if (i == 0) cyc(1'b0, 1'b1, 16'h0001, 1'b0);
      else cyc(1'b0, 1'b1, 16'($urandom), 1'b0);
      if (write_enable === 1'b1) writes++;
    end
    n_checks++;
    if (writes != 100) begin
      n_fail++;
      $display("FAIL mid_writes got %0d want 100", writes);
    end
    cyc(1'b1, 1'b1, 16'h4444, 1'b1);
    n_checks++;
    if (write_enable !== 1'b0 || read_index !== 1'b0 ||
        write_address !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_reset got we=%b ri=%b a=%h want 0 0 000",
               write_enable, read_index, write_address);
    end
    cyc(1'b0, 1'b1, 16'h8000, 1'b0);
    cyc(1'b0, 1'b1, 16'h1234, 1'b0);
    n_checks++;
    if (write_enable !== 1'b1 || write_address !== 9'h100) begin
      n_fail++;
      $display("FAIL mid_restart got we=%b a=%h want 1 100",
               write_enable, write_address);
    end
  endtask

  task automatic test_offset();
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b0);
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 16'hC000, 1'b0);
    n_checks++;
    if (write_enable !== 1'b1 || write_sample !== 8'h40) begin
      n_fail++;
      $display("FAIL offset_c000 got we=%b s=%h want 1 40",
               write_enable, write_sample);
    end
    cyc(1'b0, 1'b1, 16'h3FFF, 1'b0);
    n_checks++;
    if (write_enable !== 1'b1 || write_sample !== 8'hBF) begin
      n_fail++;
      $display("FAIL offset_3fff got we=%b s=%h want 1 bf",
               write_enable, write_sample);
    end
  endtask

  task automatic test_random();
    logic        rst, rdy, idle;
    logic [15:0] s;
    int          bad;
    bad = 0;
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 6000; i++) begin
      rst  = ($urandom_range(0, 999) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      idle = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) s = 16'($urandom);
      else s = 16'($signed(int'($urandom_range(0, 200)) - 100));
      cyc(rst, rdy, s, idle);
      n_checks++;
      if (write_enable !== m_we || write_address !== m_addr ||
          write_sample !== m_ws || read_index !== m_ri) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] got we=%b a=%h s=%h ri=%b want %b %h %h %b",
                   i, write_enable, write_address, write_sample, read_index,
                   m_we, m_addr, m_ws, m_ri);
      end
    end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    m_cnt             = 0;
    m_prev            = 0;
    m_we              = 1'b0;
    m_ri              = 1'b0;
    m_addr            = '0;
    m_ws              = '0;
    reset             = 1'b1;
    new_sample_ready  = 1'b0;
    new_sample_in     = '0;
    wave_display_idle = 1'b0;
    test_reset();
    test_trigger();
    test_negative_going();
    test_full_window();
    test_wait_swap();
    test_reset_mid();
    test_offset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
